// File: rtl/pwm_peripheral.sv
// Sixteen-channel PWM output stage: shared prescaler, 8-bit period counter and
// double-buffered duty register feeding per-channel enable/mode muxes.
//
// Ports:
//   clk, rst_n          - system clock, async active-low reset
//   en_reg_out_*        - per-channel output enables (15..8, 7..0)
//   en_reg_pwm_*        - per-channel PWM-mode enables (15..8, 7..0)
//   pwm_duty_cycle      - requested duty, taken into use at each period wrap
//   out                 - registered channel outputs
//   period_start        - one-clk pulse on the first clk of each period
module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic [15:0]   out_q, out_d;
  logic          ps_q, ps_d;

  logic          tick;
  logic          wrap;
  logic          pwm_hi;
  logic [15:0]   en_out;
  logic [15:0]   en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign tick = (pre_q == PRE_LAST);
  assign wrap = tick && (cnt_q == 8'hFF);

  // 0xFF is forced high so that full duty never shows a one-tick gap at cnt 255.
  assign pwm_hi = (duty_q == 8'hFF) || (cnt_q < duty_q);

  always_comb begin
    pre_d  = tick ? '0 : pre_q + PW'(1);
    cnt_d  = tick ? cnt_q + 8'd1 : cnt_q;
    duty_d = wrap ? pwm_duty_cycle : duty_q;
    ps_d   = wrap;
    out_d  = en_out & (~en_pwm | {16{pwm_hi}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      cnt_q  <= 8'h00;
      duty_q <= 8'h00;
      out_q  <= 16'h0000;
      ps_q   <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      out_q  <= out_d;
      ps_q   <= ps_d;
    end
  end

  assign out          = out_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed testbench for pwm_peripheral with PRESCALE = 13.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pwm_peripheral;

  localparam int P   = 13;
  localparam int PER = 256 * P;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  int total = 0;
  int bad   = 0;

  pwm_peripheral #(.PRESCALE(P)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (eo_lo),
    .en_reg_out_15_8 (eo_hi),
    .en_reg_pwm_7_0  (ep_lo),
    .en_reg_pwm_15_8 (ep_hi),
    .pwm_duty_cycle  (duty),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {eo_hi, eo_lo} = eo;
    {ep_hi, ep_lo} = ep;
  endtask

  task automatic wait_ps(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < PER + 100; i++) begin
      @(negedge clk);
      if (period_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Observes out[0] over the PER clks following a period_start sample.
  task automatic measure(input int wr_at, input logic [7:0] wr_val,
                         output int hi, output int rises,
                         output int first_rise, output int first_fall);
    logic prev;
    prev = out[0];
    hi = 0; rises = 0; first_rise = -1; first_fall = -1;
    for (int k = 1; k <= PER; k++) begin
      @(negedge clk);
      if (out[0]) hi++;
      if (out[0] && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = k;
      end
      if (!out[0] && prev && first_fall < 0) first_fall = k;
      prev = out[0];
      if (k == wr_at) duty = wr_val;
    end
  endtask

  task automatic test_reset;
    int  first;
    int  nz;
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      eo_lo = 8'($urandom); eo_hi = 8'($urandom);
      ep_lo = 8'($urandom); ep_hi = 8'($urandom);
      duty  = 8'($urandom);
      @(negedge clk);
      total++;
      if (out !== 16'h0000 || period_start !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: out=%h ps=%b want out=0000 ps=0",
                 out, period_start);
      end
    end
    set_en(16'hFFFF, 16'hFFFF);
    duty = 8'h80;
    rst_n = 1'b1;
    first = -1;
    nz = 0;
    for (int k = 1; k <= PER + 50; k++) begin
      @(negedge clk);
      if (out !== 16'h0000) nz++;
      if (period_start) begin
        first = k;
        break;
      end
    end
    total++;
    if (first !== PER) begin
      bad++;
      $display("FAIL reset_first_ps: at=%0d want %0d", first, PER);
    end
    total++;
    if (nz !== 0) begin
      bad++;
      $display("FAIL reset_first_period_low: nonzero=%0d want 0", nz);
    end
  endtask

  task automatic test_static;
    set_en(16'hFFFF, 16'h0000);
    @(negedge clk);
    total++;
    if (out !== 16'hFFFF) begin
      bad++;
      $display("FAIL static_all: out=%h want ffff", out);
    end
    set_en(16'h00F0, 16'h0000);
    @(negedge clk);
    total++;
    if (out !== 16'h00F0) begin
      bad++;
      $display("FAIL static_f0: out=%h want 00f0", out);
    end
  endtask

  task automatic test_duty;
    logic [7:0] dv [4];
    int         exp_hi [4];
    int         hi, rises, fr, ff;
    bit         ok;
    dv = '{8'h80, 8'h00, 8'hFF, 8'h01};
    exp_hi = '{1664, 0, PER, 13};
    set_en(16'h0001, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      duty = dv[i];
      wait_ps(ok);
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL duty_ps_timeout: duty=%h", dv[i]);
      end
      measure(0, 8'h00, hi, rises, fr, ff);
      total++;
      if (hi !== exp_hi[i]) begin
        bad++;
        $display("FAIL duty_hi: duty=%h high=%0d want %0d",
                 dv[i], hi, exp_hi[i]);
      end
      if (dv[i] == 8'h80) begin
        total++;
        if (fr !== 1 || rises !== 1) begin
          bad++;
          $display("FAIL duty80_rise: at=%0d n=%0d want at=1 n=1", fr, rises);
        end
      end
    end
  endtask

  task automatic test_shadow;
    int hi, rises, fr, ff;
    bit ok;
    duty = 8'h40;
    wait_ps(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL shadow_ps_timeout: no period_start");
    end
    measure(100 * P, 8'hC0, hi, rises, fr, ff);
    total++;
    if (hi !== 832 || ff !== 833) begin
      bad++;
      $display("FAIL shadow_old: high=%0d fall=%0d want 832 833", hi, ff);
    end
    total++;
    if (period_start !== 1'b1) begin
      bad++;
      $display("FAIL shadow_ps_align: ps=%b want 1", period_start);
    end
    measure(0, 8'h00, hi, rises, fr, ff);
    total++;
    if (hi !== 2496 || rises !== 1 || fr !== 1) begin
      bad++;
      $display("FAIL shadow_new: high=%0d rises=%0d at=%0d want 2496 1 1",
               hi, rises, fr);
    end
  endtask

  task automatic test_mixed;
    bit ok;
    set_en(16'hA5A5, 16'h0F0F);
    duty = 8'h80;
    wait_ps(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL mixed_ps_timeout: no period_start");
    end
    for (int k = 1; k <= 1700; k++) begin
      @(negedge clk);
      if (k == 10) begin
        total++;
        if (out !== 16'hA5A5) begin
          bad++;
          $display("FAIL mixed_high: out=%h want a5a5", out);
        end
      end
    end
    total++;
    if (out !== 16'hA0A0) begin
      bad++;
      $display("FAIL mixed_low: out=%h want a0a0", out);
    end
  endtask

  task automatic test_mid_reset;
    int hi, rises, fr, ff;
    int first;
    bit ok;
    set_en(16'h0003, 16'h0001);
    duty = 8'h80;
    wait_ps(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL midrst_ps_timeout: no period_start");
    end
    repeat (200 * P) @(negedge clk);
    total++;
    if (out !== 16'h0002) begin
      bad++;
      $display("FAIL midrst_pre: out=%h want 0002", out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out !== 16'h0000 || period_start !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async: out=%h ps=%b want 0000 0", out, period_start);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    first = -1;
    for (int k = 1; k <= PER + 50; k++) begin
      @(negedge clk);
      if (out[0]) hi++;
      if (period_start) begin
        first = k;
        break;
      end
    end
    total++;
    if (first !== PER || hi !== 0) begin
      bad++;
      $display("FAIL midrst_first: ps_at=%0d high=%0d want %0d 0",
               first, hi, PER);
    end
    measure(0, 8'h00, hi, rises, fr, ff);
    total++;
    if (hi !== 1664 || fr !== 1) begin
      bad++;
      $display("FAIL midrst_resume: high=%0d at=%0d want 1664 1", hi, fr);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_en(16'h0000, 16'h0000);
    duty = 8'h00;
    @(negedge clk);
    test_reset();
    test_static();
    test_duty();
    test_shadow();
    test_mixed();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_peripheral.md
# pwm_peripheral

Sixteen-channel PWM output stage driven by the SPI register file. It takes the five configuration bytes (output enables, PWM-mode enables, duty cycle) and produces 16 registered output pins. All enabled PWM channels share one 8-bit duty cycle and one period counter. The duty value is double-buffered so that a mid-period SPI write never glitches an output.

## Interface
- PRESCALE, default 13: clk cycles per PWM counter tick. Legal values are ≥1. PWM period = 256·PRESCALE clk cycles.
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- en_reg_out_7_0  input  8  output enable, channels 7..0
- en_reg_out_15_8  input  8  output enable, channels 15..8
- en_reg_pwm_7_0  input  8  PWM-mode enable, channels 7..0
- en_reg_pwm_15_8  input  8  PWM-mode enable, channels 15..8
- pwm_duty_cycle  input  8  requested duty value; 0x00 = 0 %, 0xFF = 100 %
- out  output  16  channel outputs; bit i is channel i
- period_start  output  1  one-clk pulse marking the first clk of each PWM period

## Operation
- Prescaler `pre` counts 0..PRESCALE-1 and wraps to 0. A tick is asserted in any clk where pre == PRESCALE-1.
- On each tick, the 8-bit period counter `cnt` increments mod 256. It holds its value between ticks.
- Wrap event: a tick occurs while cnt == 255. On this event:
  - cnt goes to 0.
  - The active duty register `duty_act` loads pwm_duty_cycle.
  - period_start is set to 1 for exactly one clk.
- duty_act is the only duty value used for comparison. Changes to pwm_duty_cycle between wraps have no effect until the next wrap.
- PWM level: pwm_hi = (duty_act == 0xFF) OR (cnt < duty_act), an unsigned 8-bit compare.
  - duty_act 0x00 keeps the output always low.
  - duty_act 0xFF keeps the output always high.
  - Any other value N gives N·PRESCALE high clks per period.
- Per-channel output (en_out = {en_reg_out_15_8, en_reg_out_7_0}, en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}):
  - en_out[i] = 0 → out[i] = 0, regardless of en_pwm[i].
  - en_out[i] = 1, en_pwm[i] = 0 → out[i] = 1 (static high).
  - en_out[i] = 1, en_pwm[i] = 1 → out[i] = pwm_hi.
- Enable changes are not shadowed. They take effect on the next clk edge and may truncate the current pulse. This is intended.
- Reset values: pre = 0, cnt = 0, duty_act = 0x00, out = 16'h0000, period_start = 0.
- After reset, duty_act stays at 0x00 until the first wrap. PWM channels therefore output low for the first period even if pwm_duty_cycle is nonzero.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronously). After release, counting restarts at pre = 0, cnt = 0.

## Timing
- All outputs are registered. out and period_start change only on rising clk, except when asynchronously cleared by rst_n.
- Latency: out[i] reflects en_out, en_pwm, cnt and duty_act as sampled at the previous clk edge. This is 1 clk from an enable change to the output.
- Wrap: period_start = 1 in the same clk in which cnt first reads 0. The first out value computed with the new duty_act appears one clk later.
- Period is exactly 256·PRESCALE clks. Consecutive period_start pulses are 256·PRESCALE clks apart.
- PRESCALE = 1: a tick occurs on every clk and pre stays at 0. The period is 256 clks.
- Inputs are synchronous to clk (the upstream register file runs on clk). No synchronisers are required.

## Test plan
- Reset: hold rst_n low with random inputs → out = 0x0000 and period_start = 0. Release rst_n → the first period_start occurs 256·PRESCALE clks later.
- Static mode: en_out = 0xFFFF, en_pwm = 0x0000 → out = 0xFFFF one clk later. Then en_out = 0x00F0 → out = 0x00F0 one clk later.
- Duty sweep, PRESCALE = 13, en_out = en_pwm = 0x0001, run after one full period:
  - duty 0x80 → exactly 1664 high clks per 3328-clk period; the rising edge is 1 clk after period_start.
  - duty 0x00 → always low.
  - duty 0xFF → always high.
  - duty 0x01 → 13 high clks.
- Shadowing: duty 0x40 active; write 0xC0 at cnt = 100 → the current period keeps 0x40 timing (falls at cnt 64). The new 832/2496 split starts at the next period_start, with no extra edge.
- Mixed channels: en_out = 0xA5A5, en_pwm = 0x0F0F, duty 0x80 → bits in 0xA5A5 & 0x0F0F toggle with PWM; bits 0xA5A5 & ~0x0F0F hold 1; all other bits hold 0.
- Reset mid-period at cnt = 200 with duty 0x80 active → out = 0 immediately and duty_act = 0. After release, the first period is all low and 50 % duty resumes after the next wrap.
